// File: rtl/video_mnist_pkg.sv
`default_nettype none
//==============================================================================
// video_mnist_pkg: shared constants, types and popcount helper for the MNIST
// result decoder.                                          Revision: 1.0
//==============================================================================
package video_mnist_pkg;

  localparam int CLASS_NUM   = 10;
  localparam int VOTE_NUM    = 7;
  localparam int COUNT_WIDTH = 3;
  localparam int CLASS_WIDTH = 4;

  typedef struct packed {
    logic [CLASS_WIDTH-1:0] cls;
    logic [COUNT_WIDTH-1:0] cnt;
  } class_count_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  function automatic logic [COUNT_WIDTH-1:0] popcount(input logic [VOTE_NUM-1:0] v);
    logic [COUNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < VOTE_NUM; i++) begin
      n = n + COUNT_WIDTH'(v[i]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_mnist_argmax.sv
`default_nettype none
//==============================================================================
// video_mnist_argmax: combinational balanced compare tree, lowest index wins
// ties.                                                    Revision: 1.0
//==============================================================================
module video_mnist_argmax #(
  parameter int N  = 10,
  parameter int CW = 3,
  parameter int IW = 4
) (
  input  logic [N*CW-1:0] i_counts,
  output logic [IW-1:0]   o_class,
  output logic [CW-1:0]   o_count
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int P  = 1 << LW;

  // Heap-ordered tree: leaves sit in index order, so the left child always
  // holds the lower indices and ">=" yields the lowest-index tie-break.
  // Padding leaves carry count 0 and can never beat a real leaf.
  function automatic logic [LW+CW-1:0] f_tree(input logic [N*CW-1:0] v);
    logic [CW-1:0] cnt [2*P-1];
    logic [LW-1:0] idx [2*P-1];
    for (int k = 0; k < 2*P-1; k++) begin
      cnt[k] = '0;
      idx[k] = '0;
    end
    for (int i = 0; i < P; i++) begin
      idx[P-1+i] = LW'(i);
    end
    for (int i = 0; i < N; i++) begin
      cnt[P-1+i] = v[i*CW +: CW];
    end
    for (int k = P-2; k >= 0; k--) begin
      if (cnt[2*k+1] >= cnt[2*k+2]) begin
        cnt[k] = cnt[2*k+1];
        idx[k] = idx[2*k+1];
      end else begin
        cnt[k] = cnt[2*k+2];
        idx[k] = idx[2*k+2];
      end
    end
    return {idx[0], cnt[0]};
  endfunction

  logic [LW+CW-1:0] w_res;

  assign w_res   = f_tree(i_counts);
  assign o_class = IW'(w_res[LW+CW-1:CW]);
  assign o_count = w_res[CW-1:0];

endmodule
`default_nettype wire

// File: rtl/video_mnist_result_decoder.sv
`default_nettype none
//==============================================================================
// video_mnist_result_decoder: per-pixel vote decoder (popcount/argmax/threshold)
// with per-frame detection histogram.                      Revision: 1.0
//==============================================================================
module video_mnist_result_decoder #(
  parameter int TUSER_WIDTH   = 1,
  parameter int CLASS_NUM     = video_mnist_pkg::CLASS_NUM,
  parameter int VOTE_NUM      = video_mnist_pkg::VOTE_NUM,
  parameter int S_TDATA_WIDTH = CLASS_NUM * VOTE_NUM,
  parameter int COUNT_WIDTH   = video_mnist_pkg::COUNT_WIDTH,
  parameter int CLASS_WIDTH   = video_mnist_pkg::CLASS_WIDTH,
  parameter int HIST_WIDTH    = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COUNT_WIDTH-1:0]   param_threshold,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [CLASS_WIDTH-1:0]   m_axi4s_tclass,
  output logic [COUNT_WIDTH-1:0]   m_axi4s_tcount,
  output logic                     m_axi4s_tdetect,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready,
  output logic [CLASS_WIDTH-1:0]   frame_class,
  output logic                     frame_valid
);

  import video_mnist_pkg::*;

  logic                             w_cke;
  logic [CLASS_NUM*COUNT_WIDTH-1:0] w_pop;
  logic [CLASS_WIDTH-1:0]           w_arg_class;
  logic [COUNT_WIDTH-1:0]           w_arg_count;

  logic                             r_s1_valid;
  logic [TUSER_WIDTH-1:0]           r_s1_user;
  logic                             r_s1_last;
  logic [CLASS_NUM*COUNT_WIDTH-1:0] r_s1_cnt;

  logic                             r_s2_valid;
  logic [TUSER_WIDTH-1:0]           r_s2_user;
  logic                             r_s2_last;
  class_count_t                     r_s2;

  logic                             r_m_valid;
  logic [TUSER_WIDTH-1:0]           r_m_user;
  logic                             r_m_last;
  logic [CLASS_WIDTH-1:0]           r_m_class;
  logic [COUNT_WIDTH-1:0]           r_m_count;
  logic                             r_m_detect;

  assign w_cke          = !r_m_valid || m_axi4s_tready;
  assign s_axi4s_tready = w_cke;

  generate
    for (genvar c = 0; c < CLASS_NUM; c++) begin : g_pop
      assign w_pop[c*COUNT_WIDTH +: COUNT_WIDTH] = popcount(s_axi4s_tdata[c*VOTE_NUM +: VOTE_NUM]);
    end
  endgenerate

  video_mnist_argmax #(
    .N  (CLASS_NUM),
    .CW (COUNT_WIDTH),
    .IW (CLASS_WIDTH)
  ) u_argmax (
    .i_counts (r_s1_cnt),
    .o_class  (w_arg_class),
    .o_count  (w_arg_count)
  );

  // All three stages advance together; a stalled output freezes the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_user  <= '0;
      r_s1_last  <= 1'b0;
      r_s1_cnt   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_user  <= '0;
      r_s2_last  <= 1'b0;
      r_s2       <= '0;
      r_m_valid  <= 1'b0;
      r_m_user   <= '0;
      r_m_last   <= 1'b0;
      r_m_class  <= '0;
      r_m_count  <= '0;
      r_m_detect <= 1'b0;
    end else if (w_cke) begin
      r_s1_valid <= s_axi4s_tvalid;
      r_s1_user  <= s_axi4s_tuser;
      r_s1_last  <= s_axi4s_tlast;
      r_s1_cnt   <= w_pop;
      r_s2_valid <= r_s1_valid;
      r_s2_user  <= r_s1_user;
      r_s2_last  <= r_s1_last;
      r_s2.cls   <= w_arg_class;
      r_s2.cnt   <= w_arg_count;
      r_m_valid  <= r_s2_valid;
      r_m_user   <= r_s2_user;
      r_m_last   <= r_s2_last;
      r_m_class  <= r_s2.cls;
      r_m_count  <= r_s2.cnt;
      r_m_detect <= (r_s2.cnt >= param_threshold);
    end
  end

  assign m_axi4s_tvalid  = r_m_valid;
  assign m_axi4s_tuser   = r_m_user;
  assign m_axi4s_tlast   = r_m_last;
  assign m_axi4s_tclass  = r_m_class;
  assign m_axi4s_tcount  = r_m_count;
  assign m_axi4s_tdetect = r_m_detect;

  logic                  w_xfer;
  logic                  w_sof;
  logic                  r_in_frame;
  logic [HIST_WIDTH-1:0] r_hist   [CLASS_NUM];
  logic [HIST_WIDTH-1:0] r_shadow [CLASS_NUM];

  assign w_xfer = r_m_valid && m_axi4s_tready;
  assign w_sof  = r_m_user[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_frame <= 1'b0;
      for (int c = 0; c < CLASS_NUM; c++) begin
        r_hist[c] <= '0;
      end
    end else if (w_xfer) begin
      if (w_sof) begin
        r_in_frame <= 1'b1;
        for (int c = 0; c < CLASS_NUM; c++) begin
          r_hist[c] <= (r_m_detect && (r_m_class == CLASS_WIDTH'(c))) ? HIST_WIDTH'(1) : '0;
        end
      end else if (r_m_detect) begin
        for (int c = 0; c < CLASS_NUM; c++) begin
          if ((r_m_class == CLASS_WIDTH'(c)) && (r_hist[c] != '1)) begin
            r_hist[c] <= r_hist[c] + 1'b1;
          end
        end
      end
    end
  end

  scan_state_t            r_state;
  logic [CLASS_WIDTH-1:0] r_idx;
  logic [CLASS_WIDTH-1:0] r_best_idx;
  logic [HIST_WIDTH-1:0]  r_best_val;
  logic [CLASS_WIDTH-1:0] r_frame_class;
  logic                   r_frame_valid;

  // A new SOF always restarts the scan, discarding any scan in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_best_idx    <= '0;
      r_best_val    <= '0;
      r_frame_class <= '0;
      r_frame_valid <= 1'b0;
      for (int c = 0; c < CLASS_NUM; c++) begin
        r_shadow[c] <= '0;
      end
    end else if (w_xfer && w_sof && r_in_frame) begin
      r_shadow   <= r_hist;
      r_state    <= ST_SCAN;
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_val <= '0;
    end else begin
      case (r_state)
        ST_SCAN: begin
          if (r_shadow[r_idx] > r_best_val) begin
            r_best_val <= r_shadow[r_idx];
            r_best_idx <= r_idx;
          end
          if (r_idx == CLASS_WIDTH'(CLASS_NUM - 1)) begin
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_frame_class <= r_best_idx;
          r_frame_valid <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign frame_class = r_frame_class;
  assign frame_valid = r_frame_valid;

endmodule
`default_nettype wire

// File: tb/tb_video_mnist_result_decoder.sv
`default_nettype none
//==============================================================================
// tb_video_mnist_result_decoder: directed scoreboard bench for the MNIST result
// decoder (two instances: default and 4-bit histogram).    Revision: 1.0
//==============================================================================
module tb_video_mnist_result_decoder;

  localparam int CN = 10;
  localparam int VN = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  thr;
  logic        s_user;
  logic        s_last;
  logic [69:0] s_data;
  logic        s_valid;
  logic        m_ready;

  logic        s_ready,  m_user,  m_last,  m_detect,  m_valid,  f_valid;
  logic [3:0]  m_class,  f_class;
  logic [2:0]  m_count;
  logic        s_ready2, m_user2, m_last2, m_detect2, m_valid2, f_valid2;
  logic [3:0]  m_class2, f_class2;
  logic [2:0]  m_count2;

  logic [9:0]  obs, obs2;
  assign obs  = {m_user,  m_last,  m_class,  m_count,  m_detect};
  assign obs2 = {m_user2, m_last2, m_class2, m_count2, m_detect2};

  always #5 clk = ~clk;

  video_mnist_result_decoder dut (
    .clk(clk), .reset(reset), .param_threshold(thr),
    .s_axi4s_tuser(s_user), .s_axi4s_tlast(s_last), .s_axi4s_tdata(s_data),
    .s_axi4s_tvalid(s_valid), .s_axi4s_tready(s_ready),
    .m_axi4s_tuser(m_user), .m_axi4s_tlast(m_last), .m_axi4s_tclass(m_class),
    .m_axi4s_tcount(m_count), .m_axi4s_tdetect(m_detect), .m_axi4s_tvalid(m_valid),
    .m_axi4s_tready(m_ready), .frame_class(f_class), .frame_valid(f_valid)
  );

  video_mnist_result_decoder #(.HIST_WIDTH(4)) dut2 (
    .clk(clk), .reset(reset), .param_threshold(thr),
    .s_axi4s_tuser(s_user), .s_axi4s_tlast(s_last), .s_axi4s_tdata(s_data),
    .s_axi4s_tvalid(s_valid), .s_axi4s_tready(s_ready2),
    .m_axi4s_tuser(m_user2), .m_axi4s_tlast(m_last2), .m_axi4s_tclass(m_class2),
    .m_axi4s_tcount(m_count2), .m_axi4s_tdetect(m_detect2), .m_axi4s_tvalid(m_valid2),
    .m_axi4s_tready(m_ready), .frame_class(f_class2), .frame_valid(f_valid2)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [9:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [69:0] vote(input int c, input int n);
    logic [69:0] v;
    v = '0;
    for (int j = 0; j < n; j++) v[c*VN + j] = 1'b1;
    return v;
  endfunction

  // Reference: popcount, strict-greater scan (lowest index wins), threshold.
  function automatic logic [9:0] model(input logic [69:0] d, input logic [2:0] t,
                                       input logic u, input logic l);
    int best = 0;
    int bc   = 0;
    int n;
    for (int c = 0; c < CN; c++) begin
      n = $countones(d[c*VN +: VN]);
      if (n > bc) begin
        bc   = n;
        best = c;
      end
    end
    return {u, l, 4'(best), 3'(bc), (3'(bc) >= t)};
  endfunction

  // Output monitor: handshake rule, stall stability, scoreboard pop.
  logic       stall_q = 1'b0;
  logic [9:0] prev_out = '0;
  always @(negedge clk) begin
    if (reset) begin
      stall_q <= 1'b0;
    end else begin
      chk("s_tready", 32'(s_ready), 32'(!m_valid || m_ready));
      chk("s_tready_dut2", 32'(s_ready2), 32'(!m_valid2 || m_ready));
      if (stall_q) chk("stall_hold", 32'({m_valid, obs}), 32'({1'b1, prev_out}));
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 32'(sb.size()), 32'd1);
        end else begin
          chk("beat", 32'(obs), 32'(sb[0]));
          chk("beat_dut2", 32'({m_valid2, obs2}), 32'({1'b1, sb[0]}));
          sb.delete(0);
        end
      end
      stall_q  <= m_valid && !m_ready;
      prev_out <= obs;
    end
  end

  logic [3:0] pat = 4'b1001;
  logic       pat_en = 1'b0;
  int         pc = 0;
  initial forever begin
    @(posedge clk); #1;
    if (pat_en) begin
      m_ready = pat[pc % 4];
      pc++;
    end
  end

  task automatic send(input logic [69:0] d, input logic u, input logic l);
    int   t = 0;
    logic acc = 1'b0;
    s_data = d; s_user = u; s_last = l; s_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = s_ready;
      if (acc) sb.push_back(model(d, thr, u, l));
      @(posedge clk); #1;
      t++;
      if (!acc && t > 50) begin
        chk("send_timeout", 32'(t), 32'd0);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Single beat into an empty pipe: output must appear exactly 3 cycles later.
  task automatic send_check(input string tag, input logic [69:0] d, input logic u,
                            input logic l, input logic [9:0] e);
    send(d, u, l);
    chk({tag, "_lat1"}, 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_lat2"}, 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(m_valid), 32'd1);
    chk({tag, "_out"}, 32'(obs), 32'(e));
    drain();
  endtask

  task automatic wait_latch(input logic [3:0] e1, input logic [3:0] e2,
                            input bit check_class, input bit exact);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(m_valid && m_ready && m_user) && t < 100);
    chk("sof_seen", 32'(t < 100), 32'd1);
    repeat (CN + 1) @(posedge clk);
    #1;
    if (exact) chk("frame_valid_early", 32'(f_valid), 32'd0);
    @(posedge clk); #1;
    chk("frame_valid", 32'(f_valid), 32'd1);
    chk("frame_valid_dut2", 32'(f_valid2), 32'd1);
    if (check_class) begin
      chk("frame_class", 32'(f_class), 32'(e1));
      chk("frame_class_dut2", 32'(f_class2), 32'(e2));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [95:0] rnd;
    reset = 1'b1; thr = 3'd4; s_user = 1'b0; s_last = 1'b0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 32'(s_ready), 32'd1);
    chk("rst_m_tvalid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(obs), 32'd0);
    chk("rst_frame", 32'({f_valid, f_class}), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    thr = 3'd4;
    send_check("full_class3", vote(3, 7), 1'b1, 1'b1, {1'b1, 1'b1, 4'd3, 3'd7, 1'b1});
    thr = 3'd6;
    send_check("tie_2_6", vote(2, 5) | vote(6, 5), 1'b0, 1'b0, {1'b0, 1'b0, 4'd2, 3'd5, 1'b0});
    thr = 3'd0;
    send_check("all_zero", '0, 1'b0, 1'b1, {1'b0, 1'b1, 4'd0, 3'd0, 1'b1});
    thr = 3'd7;
    send_check("tie_0_9", vote(0, 7) | vote(9, 7), 1'b0, 1'b1, {1'b0, 1'b1, 4'd0, 3'd7, 1'b1});

    thr = 3'd3;
    pat_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      send(rnd[69:0], 1'b0, (i % 8) == 7);
    end
    pat_en = 1'b0;
    m_ready = 1'b1;
    drain();

    thr = 3'd4;
    send('0, 1'b1, 1'b0);
    wait_latch(4'd0, 4'd0, 1'b0, 1'b1);
    drain();

    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vote(4, 7), 1'b0, 1'b0);
    chk("stalled_full", 32'(m_valid), 32'd1);
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("midrst_s_tready", 32'(s_ready), 32'd1);
    chk("midrst_m_tvalid", 32'(m_valid), 32'd0);
    chk("midrst_m_data", 32'(obs), 32'd0);
    chk("midrst_frame", 32'({f_valid, f_class}), 32'd0);
    reset = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;

    send('0, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("fresh_sof_no_valid", 32'(f_valid), 32'd0);
    chk("fresh_sof_no_valid_dut2", 32'(f_valid2), 32'd0);
    for (int i = 1; i < 784; i++) begin
      if (i <= 500)      send(vote(7, 6) | vote(0, 3), 1'b0, (i % 28) == 27);
      else if (i <= 700) send(vote(1, 4) | vote(9, 2), 1'b0, (i % 28) == 27);
      else               send('0, 1'b0, (i % 28) == 27);
    end
    send('0, 1'b1, 1'b0);
    wait_latch(4'd7, 4'd1, 1'b1, 1'b1);

    for (int i = 0; i < 20; i++) send(vote(5, 7), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send(vote(2, 7), 1'b0, 1'b0);
    send('0, 1'b1, 1'b0);
    wait_latch(4'd5, 4'd5, 1'b1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
